interfpga_send_fifo: RTL

- Buffered transmitter for the 4-bit nibble link (data lines plus ctrl line) between two FPGAs.
- Software or upstream logic pushes bytes into an internal FIFO without waiting on the link.
- The block drains the FIFO onto the wire, back-to-back, with the minimum legal idle gap.
- Wire format is identical to the existing nibble link, so the existing link receiver decodes it unchanged.

---
 rtl/interfpga_send_fifo_if.sv | 26 ++
 rtl/interfpga_send_fifo.sv | 133 +++++++++++++
 2 files changed

// File: rtl/interfpga_send_fifo_if.sv
// Host-side write port, status flags and nibble link lines of the buffered
// inter-FPGA transmitter.
interface interfpga_send_fifo_if #(
  parameter int unsigned AW = 3
);
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        full;
  logic        empty;
  logic [AW:0] level;
  logic        overflow;
  logic        clr_overflow;
  logic        busy;
  logic [3:0]  data_o;
  logic        ctrl_o;

  modport master (
    output wr_data, wr_en, clr_overflow,
    input  full, empty, level, overflow, busy, data_o, ctrl_o
  );

  modport slave (
    input  wr_data, wr_en, clr_overflow,
    output full, empty, level, overflow, busy, data_o, ctrl_o
  );
endinterface

// File: rtl/interfpga_send_fifo.sv
// Buffered transmitter for the 4-bit nibble link: bytes are queued in a FIFO
// and sent back-to-back as 4-cycle ctrl-high frames separated by a ctrl-low gap.
module interfpga_send_fifo #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AW         = 3,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  interfpga_send_fifo_if.slave  bus
);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q, overflow_q, busy_q, ctrl_q;
  logic [3:0]    data_q;

  logic [1:0]    state_q, state_d;
  logic [1:0]    sub_q, sub_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          push_c, pop_c, ctrl_d;
  logic [3:0]    data_d;

  assign push_c = bus.wr_en & ~full_q;

  // Storage array, no reset needed: validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= bus.wr_data;
  end

  // Next state, pop decision and next link outputs.
  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    gap_d     = gap_q;
    pop_c     = 1'b0;
    tx_byte_d = tx_byte_q;
    ctrl_d    = 1'b0;
    data_d    = 4'h0;

    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          state_d = S_SEND;
          sub_d   = 2'd0;
          pop_c   = 1'b1;
        end
      end
      S_SEND: begin
        if (sub_q == 2'd3) begin
          state_d = S_GAP;
          gap_d   = GW'(1);
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES)) begin
          if (!empty_q) begin
            state_d = S_SEND;
            sub_d   = 2'd0;
            pop_c   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop_c) tx_byte_d = mem[rd_ptr];

    // Low nibble on sub 0/1, high nibble on sub 2/3.
    if (state_d == S_SEND) begin
      ctrl_d = 1'b1;
      data_d = sub_d[1] ? tx_byte_d[7:4] : tx_byte_d[3:0];
    end

    level_d = level_q + LW'(push_c) - LW'(pop_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sub_q      <= 2'd0;
      gap_q      <= '0;
      tx_byte_q  <= 8'h00;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      ctrl_q     <= 1'b0;
      data_q     <= 4'h0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      gap_q     <= gap_d;
      tx_byte_q <= tx_byte_d;
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
      // A dropped write wins over a same-cycle clear.
      if (bus.wr_en && full_q)  overflow_q <= 1'b1;
      else if (bus.clr_overflow) overflow_q <= 1'b0;
      busy_q <= (state_d != S_IDLE) | (level_d != '0);
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
  assign bus.ctrl_o   = ctrl_q;
  assign bus.data_o   = data_q;
endmodule
